// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scan-code sequencer: turns make/break/extended byte streams
// into one 0-25 letter index per key press, queued in a small FWFT FIFO.
// Ports:
//   clk, rst_l          clock, async active-low reset
//   key_rdy, key_byte   one-cycle strobe with received scan-code byte
//   letter_valid/letter FIFO head (0=A..25=Z), letter_ready pops it
//   held_valid          a letter key is currently held down
//   overflow            sticky FIFO-full drop flag, clr_overflow clears it
//   drop_count          saturating count of discarded non-letter makes
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 2000000,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       key_rdy,
  input  logic [7:0] key_byte,
  output logic       letter_valid,
  output logic [4:0] letter,
  input  logic       letter_ready,
  output logic       held_valid,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic [7:0] drop_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    held_q, held_d;
  logic          hv_q, hv_d;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic [4:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       is_letter;
  logic [4:0] map_idx;
  logic       push;
  logic       drop_inc;
  logic       pop;
  logic       full;
  logic       wr;

  always_comb begin
    is_letter = 1'b1;
    map_idx   = 5'd0;
    case (key_byte)
      8'h1C: map_idx = 5'd0;
      8'h32: map_idx = 5'd1;
      8'h21: map_idx = 5'd2;
      8'h23: map_idx = 5'd3;
      8'h24: map_idx = 5'd4;
      8'h2B: map_idx = 5'd5;
      8'h34: map_idx = 5'd6;
      8'h33: map_idx = 5'd7;
      8'h43: map_idx = 5'd8;
      8'h3B: map_idx = 5'd9;
      8'h42: map_idx = 5'd10;
      8'h4B: map_idx = 5'd11;
      8'h3A: map_idx = 5'd12;
      8'h31: map_idx = 5'd13;
      8'h44: map_idx = 5'd14;
      8'h4D: map_idx = 5'd15;
      8'h15: map_idx = 5'd16;
      8'h2D: map_idx = 5'd17;
      8'h1B: map_idx = 5'd18;
      8'h2C: map_idx = 5'd19;
      8'h3C: map_idx = 5'd20;
      8'h2A: map_idx = 5'd21;
      8'h1D: map_idx = 5'd22;
      8'h22: map_idx = 5'd23;
      8'h35: map_idx = 5'd24;
      8'h1A: map_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    held_d   = held_q;
    hv_d     = hv_q;
    push     = 1'b0;
    drop_inc = 1'b0;
    if (key_rdy) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (key_byte == 8'hF0) begin
            state_d = S_BRK;
          end else if (key_byte == 8'hE0) begin
            state_d = S_EXT;
          end else if (is_letter) begin
            // Typematic repeat of the held key is swallowed silently
            if (!(SUPPRESS_REPEAT && hv_q && map_idx == held_q)) begin
              held_d = map_idx;
              hv_d   = 1'b1;
              push   = 1'b1;
            end
          end else begin
            drop_inc = 1'b1;
          end
        end
        S_EXT: begin
          if (key_byte == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            state_d  = S_IDLE;
            drop_inc = 1'b1;
          end
        end
        S_BRK: begin
          state_d = S_IDLE;
          if (is_letter && map_idx == held_q) hv_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // Abandon a truncated prefix sequence
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = S_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_inc && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  assign pop  = (cnt_q != '0) && letter_ready;
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot the push needs
  assign wr   = push && (!full || pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (wr) wptr_d = wptr_q + 1'b1;
    if (pop) rptr_d = rptr_q + 1'b1;
    if (wr && !pop) cnt_d = cnt_q + 1'b1;
    if (!wr && pop) cnt_d = cnt_q - 1'b1;
    if (clr_overflow) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      held_q  <= '0;
      hv_q    <= 1'b0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      hv_q    <= hv_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      if (wr) mem_q[wptr_q] <= map_idx;
    end
  end

  assign letter_valid = (cnt_q != '0);
  assign letter       = letter_valid ? mem_q[rptr_q] : 5'd0;
  assign held_valid   = hv_q;
  assign overflow     = ovf_q;
  assign drop_count   = drop_q;

endmodule
